fetch_queue: RTL and testbench
==============================

# fetch_queue

Decoupled instruction-fetch front end that sits directly upstream of the decode pipeline register. It generates the program counter, issues in-order requests to an instruction memory over a valid/ready handshake, and buffers returned instructions in a small FIFO. It presents one instruction per cycle to decode, together with its PC and PC+4. A redirect from execute (`pcsrc`/`pctarget`) flushes queued and in-flight instructions and restarts fetch at the target.

## Interface
- `WIDTH`, 32, data/address width
- `DEPTH`, 4, FIFO entries; also the maximum number of in-flight plus buffered instructions (power of two, ≥2)
- `RESET_PC`, 32'h0, first fetch address after reset
- `clk`  in  1  clock; all state updates on the rising edge
- `rst`  in  1  asynchronous, active-low reset
- `pcsrc`  in  1  redirect strobe from execute (taken branch/jump)
- `pctarget`  in  WIDTH  redirect address; sampled when `pcsrc`=1
- `imem_req_valid`  out  1  fetch request valid
- `imem_req_ready`  in  1  memory accepts the request
- `imem_req_addr`  out  WIDTH  fetch address (word aligned)
- `imem_rsp_valid`  in  1  instruction returned; in order, ≥1 cycle after acceptance
- `imem_rsp_data`  in  WIDTH  returned instruction
- `instr_valid`  out  1  FIFO head valid
- `instr_ready`  in  1  decode consumes the head (0 = decode stall)
- `instrF`  out  WIDTH  head instruction
- `pcF`  out  WIDTH  PC of the head instruction
- `pcplus4F`  out  WIDTH  `pcF`+4, modulo 2^WIDTH
- `rsp_err`  out  1  sticky: a response arrived with nothing outstanding

## Operation
- Registers: `pc_q` (next fetch address), FIFO of {instr, pc} × DEPTH, `outstanding` and `discard` counters of width $clog2(DEPTH)+1, and FSM state.
- FSM states: RUN (no stale responses pending) and DRAIN (`discard`>0).
  - RUN→DRAIN: on `pcsrc` when in-flight count after this cycle > 0.
  - DRAIN→RUN: when `discard` reaches 0.
  - `pcsrc` in DRAIN stays in DRAIN and reloads `discard`.
- Request: `imem_req_valid` = !`pcsrc` && (`outstanding` + FIFO count < DEPTH). `imem_req_addr` = `pc_q`. On acceptance, `pc_q` += 4 (wraps) and `outstanding` increments.
- Response: `outstanding` decrements.
  - If `discard`>0: the response is dropped and `discard` decrements.
  - Otherwise: {data, pc of that request} is pushed to the FIFO. A PC queue inside the FIFO tracks request addresses in order.
- Pop: when `instr_valid` && `instr_ready`.
- Push and pop in the same cycle are both honoured; the count is unchanged. The credit rule guarantees a push never hits a full FIFO.
- Redirect (`pcsrc`=1), applied at that edge:
  - FIFO emptied; any same-cycle pop or push is ignored.
  - `pc_q` ← `pctarget`.
  - `discard` ← `outstanding` after this cycle's decrement.
  - No request is issued in the `pcsrc` cycle.
- Response with `outstanding`=0: ignored; `rsp_err` ← 1 until reset.
- Reset values: `pc_q`=RESET_PC, FIFO empty, both counters 0, state RUN, `rsp_err`=0. All outputs 0 while `rst`=0, including `imem_req_valid`, `instr_valid`, `instrF`, `pcF` and `pcplus4F`.
- When `instr_valid`=0, `instrF`, `pcF` and `pcplus4F` read 0.

## Timing
- First request in the first clock edge cycle after `rst` rises, at address RESET_PC.
- With 1-cycle memory latency and decode always ready:
  - the response is pushed at the end of cycle 1;
  - `instr_valid` rises in cycle 2 (2-cycle fetch-to-decode latency);
  - steady-state throughput is 1 instruction/cycle.
- No combinational path from `imem_rsp_*` to `instr_*`. The head is always registered.
- `imem_req_valid` depends combinationally on `pcsrc`. `imem_req_addr` is purely registered.
- After `pcsrc` in cycle N: first request to `pctarget` in cycle N+1. Earliest `instr_valid` for the target is N+3, plus any DRAIN time.
- Reset asserted mid-operation clears everything immediately. Responses to pre-reset requests must not be returned by memory; if they are, `rsp_err` is set.

## Test plan
- Reset release, 1-cycle memory, `instr_ready`=1 → requests 0x0, 0x4, 0x8…; `instr_valid` from cycle 2; `pcF` 0x0, 0x4…; `pcplus4F`=`pcF`+4.
- Hold `instr_ready`=0 → exactly 4 requests issued, then `imem_req_valid`=0; FIFO head stays at `pcF`=0x0. Releasing → 4 pops on consecutive cycles, requests resume.
- 3-cycle memory latency, 3 in flight, `pcsrc`=1 with `pctarget`=0x100 → DRAIN; 3 stale responses dropped; first delivered `pcF`=0x100; no stale instruction ever reaches `instr_valid`.
- `pcsrc` in the same cycle as a push, a pop and `imem_req_ready`=1 → no request accepted that cycle; FIFO empty next cycle; next request address 0x100.
- `pc_q`=0xFFFFFFFC → next request 0x0; `pcplus4F`=0x0 for that instruction.
- Spurious `imem_rsp_valid` with `outstanding`=0 → FIFO unchanged; `rsp_err`=1 and stays set until `rst`=0.

Source files
------------

// File: rtl/fetch_queue_if.sv
// Bus bundle between the fetch front end, the instruction memory and decode.
// The master view belongs to fetch_queue; the slave view is the environment
// (memory request/response side plus the decode consumer).
interface fetch_queue_if #(
    parameter int WIDTH = 32
);
    logic             imem_req_valid;
    logic             imem_req_ready;
    logic [WIDTH-1:0] imem_req_addr;
    logic             imem_rsp_valid;
    logic [WIDTH-1:0] imem_rsp_data;
    logic             instr_valid;
    logic             instr_ready;
    logic [WIDTH-1:0] instrF;
    logic [WIDTH-1:0] pcF;
    logic [WIDTH-1:0] pcplus4F;

    modport master (
        output imem_req_valid, imem_req_addr,
        input  imem_req_ready,
        input  imem_rsp_valid, imem_rsp_data,
        output instr_valid, instrF, pcF, pcplus4F,
        input  instr_ready
    );

    modport slave (
        input  imem_req_valid, imem_req_addr,
        output imem_req_ready,
        output imem_rsp_valid, imem_rsp_data,
        input  instr_valid, instrF, pcF, pcplus4F,
        output instr_ready
    );
endinterface

// File: rtl/fetch_queue.sv
// Decoupled fetch front end: generates the PC, issues credit-limited in-order
// requests to instruction memory and buffers returned instructions in a small
// FIFO ahead of decode. A redirect flushes the FIFO and drops responses that
// belong to requests issued before it.
module fetch_queue #(
    parameter int               WIDTH    = 32,
    parameter int               DEPTH    = 4,
    parameter logic [WIDTH-1:0] RESET_PC = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             pcsrc,
    input  logic [WIDTH-1:0] pctarget,
    fetch_queue_if.master    bus,
    output logic             rsp_err
);
    localparam int          AW      = $clog2(DEPTH);
    localparam int          CW      = $clog2(DEPTH) + 1;
    localparam logic [CW:0] DEPTH_V = (CW + 1)'(DEPTH);

    localparam logic [0:0] RUN   = 1'b0;
    localparam logic [0:0] DRAIN = 1'b1;

    logic [WIDTH-1:0] pc_q, pc_d;
    logic [WIDTH-1:0] rsp_pc_q, rsp_pc_d;
    logic [AW-1:0]    head_q, head_d;
    logic [AW-1:0]    tail_q, tail_d;
    logic [CW-1:0]    count_q, count_d;
    logic [CW-1:0]    outstanding_q, outstanding_d;
    logic [CW-1:0]    discard_q, discard_d;
    logic [0:0]       state_q, state_d;
    logic             rsp_err_q, rsp_err_d;
    logic [WIDTH-1:0] fifo_instr_q [DEPTH];
    logic [WIDTH-1:0] fifo_instr_d [DEPTH];
    logic [WIDTH-1:0] fifo_pc_q [DEPTH];
    logic [WIDTH-1:0] fifo_pc_d [DEPTH];

    logic             req_valid;
    logic             req_fire;
    logic             head_valid;
    logic             rsp_accept;
    logic             rsp_spurious;
    logic             push;
    logic             pop;
    logic [CW:0]      occupancy;

    // Handshake qualifiers; a request needs a free slot counting in-flight plus buffered
    always_comb begin
        occupancy    = {1'b0, outstanding_q} + {1'b0, count_q};
        req_valid    = rst && !pcsrc && (occupancy < DEPTH_V);
        req_fire     = req_valid && bus.imem_req_ready;
        head_valid   = (count_q != '0);
        rsp_accept   = bus.imem_rsp_valid && (outstanding_q != '0);
        rsp_spurious = bus.imem_rsp_valid && (outstanding_q == '0);
        push         = rsp_accept && (state_q == RUN) && !pcsrc;
        pop          = head_valid && bus.instr_ready && !pcsrc;
    end

    assign bus.imem_req_valid = req_valid;
    assign bus.imem_req_addr  = rst ? pc_q : '0;
    assign bus.instr_valid    = head_valid;
    assign bus.instrF         = head_valid ? fifo_instr_q[head_q] : '0;
    assign bus.pcF            = head_valid ? fifo_pc_q[head_q] : '0;
    assign bus.pcplus4F       = head_valid ? fifo_pc_q[head_q] + WIDTH'(4) : '0;
    assign rsp_err            = rsp_err_q;

    // Next-state for PC, counters, FIFO and the RUN/DRAIN controller
    always_comb begin
        pc_d          = pc_q;
        rsp_pc_d      = rsp_pc_q;
        head_d        = head_q;
        tail_d        = tail_q;
        fifo_instr_d  = fifo_instr_q;
        fifo_pc_d     = fifo_pc_q;
        discard_d     = discard_q;
        state_d       = state_q;
        rsp_err_d     = rsp_err_q || rsp_spurious;
        outstanding_d = outstanding_q + CW'(req_fire) - CW'(rsp_accept);
        count_d       = count_q + CW'(push) - CW'(pop);

        if (req_fire) begin
            pc_d = pc_q + WIDTH'(4);
        end

        if (rsp_accept && (state_q == DRAIN)) begin
            discard_d = discard_q - CW'(1);
        end

        // Responses are in order and requests are sequential between redirects,
        // so the PC of the next kept response is just a running address that
        // restarts at the redirect target; stale responses never consume it.
        if (push) begin
            fifo_instr_d[tail_q] = bus.imem_rsp_data;
            fifo_pc_d[tail_q]    = rsp_pc_q;
            tail_d               = tail_q + AW'(1);
            rsp_pc_d             = rsp_pc_q + WIDTH'(4);
        end

        if (pop) begin
            head_d = head_q + AW'(1);
        end

        if (pcsrc) begin
            head_d    = '0;
            tail_d    = '0;
            count_d   = '0;
            pc_d      = pctarget;
            rsp_pc_d  = pctarget;
            discard_d = outstanding_d;
        end

        case (state_q)
            RUN:     if (pcsrc && (outstanding_d != '0)) state_d = DRAIN;
            DRAIN:   if (discard_d == '0) state_d = RUN;
            default: state_d = RUN;
        endcase
    end

    // State registers with asynchronous active-low reset
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc_q          <= RESET_PC;
            rsp_pc_q      <= RESET_PC;
            head_q        <= '0;
            tail_q        <= '0;
            count_q       <= '0;
            outstanding_q <= '0;
            discard_q     <= '0;
            state_q       <= RUN;
            rsp_err_q     <= 1'b0;
            fifo_instr_q  <= '{default: '0};
            fifo_pc_q     <= '{default: '0};
        end else begin
            pc_q          <= pc_d;
            rsp_pc_q      <= rsp_pc_d;
            head_q        <= head_d;
            tail_q        <= tail_d;
            count_q       <= count_d;
            outstanding_q <= outstanding_d;
            discard_q     <= discard_d;
            state_q       <= state_d;
            rsp_err_q     <= rsp_err_d;
            fifo_instr_q  <= fifo_instr_d;
            fifo_pc_q     <= fifo_pc_d;
        end
    end
endmodule

// File: tb/tb_fetch_queue.sv
// Randomized scoreboard bench for fetch_queue. A behavioural memory model
// answers requests in order after a random latency; every accepted request
// pushes its expected {instruction, pc} into a scoreboard queue that a
// redirect empties, and a separate monitor compares the decode-side head.
module tb_fetch_queue;
    localparam int WIDTH = 32;
    localparam int DEPTH = 4;

    typedef struct {
        logic [31:0] addr;
        int          due;
        bit          stale;
    } mem_req_t;

    typedef struct {
        logic [31:0] instr;
        logic [31:0] pc;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        pcsrc = 1'b0;
    logic [31:0] pctarget = 32'h0;
    logic        rsp_err;

    fetch_queue_if #(.WIDTH(WIDTH)) bus ();

    fetch_queue #(
        .WIDTH(WIDTH),
        .DEPTH(DEPTH),
        .RESET_PC(32'h0)
    ) dut (
        .clk(clk),
        .rst(rst),
        .pcsrc(pcsrc),
        .pctarget(pctarget),
        .bus(bus.master),
        .rsp_err(rsp_err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int cycle = 0;
    int first_valid = -1;

    mem_req_t    pend_q[$];
    exp_t        exp_q[$];
    logic [31:0] model_pc = 32'h0;
    int          fifo_cnt = 0;
    bit          err_model = 1'b0;

    int          lat_min = 1;
    int          lat_max = 1;
    int          ready_pct = 100;
    int          dec_pct = 100;
    int          rsp_pct = 100;
    int          redirect_pct = 0;
    bit          force_redirect = 1'b0;
    logic [31:0] forced_target = 32'h0;
    bit          force_spurious = 1'b0;

    function automatic logic [31:0] memData(input logic [31:0] addr);
        return (addr * 32'h9E37_79B1) ^ 32'h1357_9BDF;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("[TB] FAIL %s: got %h expected %h (cycle %0d)", name, act, req, cycle);
        end
    endtask

    // Drives one cycle of inputs; called just after the rising edge
    task automatic applyStimulus();
        logic [31:0] tgt;
        bus.imem_req_ready = ($urandom_range(0, 99) < ready_pct);
        bus.instr_ready    = ($urandom_range(0, 99) < dec_pct);
        tgt = $urandom() & 32'h0000_0FFC;
        if ($urandom_range(0, 7) == 0) tgt = 32'hFFFF_FFF0 | (tgt & 32'h0000_000C);
        pcsrc    = force_redirect || ($urandom_range(0, 99) < redirect_pct);
        pctarget = force_redirect ? forced_target : tgt;
        force_redirect = 1'b0;
        if (force_spurious) begin
            bus.imem_rsp_valid = 1'b1;
            bus.imem_rsp_data  = 32'hDEAD_BEEF;
            force_spurious     = 1'b0;
        end else if (pend_q.size() > 0 && pend_q[0].due <= cycle && $urandom_range(0, 99) < rsp_pct) begin
            bus.imem_rsp_valid = 1'b1;
            bus.imem_rsp_data  = memData(pend_q[0].addr);
        end else begin
            bus.imem_rsp_valid = 1'b0;
            bus.imem_rsp_data  = $urandom();
        end
    endtask

    // Request-side checks and reference model update at the falling edge
    task automatic observeCycle();
        bit       exp_req_valid;
        bit       pop_m;
        mem_req_t m;
        exp_t     e;
        exp_req_valid = !pcsrc && ((pend_q.size() + fifo_cnt) < DEPTH);
        pop_m         = (fifo_cnt > 0) && bus.instr_ready && !pcsrc;
        checkOutput("req_valid", 32'(bus.imem_req_valid), 32'(exp_req_valid));
        checkOutput("instr_valid", 32'(bus.instr_valid), 32'(fifo_cnt > 0));
        checkOutput("rsp_err", 32'(rsp_err), 32'(err_model));
        if (exp_req_valid) checkOutput("req_addr", bus.imem_req_addr, model_pc);
        if (bus.instr_valid && first_valid < 0) first_valid = cycle;

        if (bus.imem_rsp_valid) begin
            if (pend_q.size() == 0) err_model = 1'b1;
            else begin
                if (!pend_q[0].stale && !pcsrc) fifo_cnt++;
                void'(pend_q.pop_front());
            end
        end
        if (pop_m) fifo_cnt--;
        if (exp_req_valid && bus.imem_req_ready) begin
            e.instr = memData(model_pc);
            e.pc    = model_pc;
            exp_q.push_back(e);
            m.addr  = model_pc;
            m.due   = cycle + $urandom_range(lat_min, lat_max);
            m.stale = 1'b0;
            pend_q.push_back(m);
            model_pc = model_pc + 32'd4;
        end
        if (pcsrc) begin
            exp_q.delete();
            foreach (pend_q[i]) pend_q[i].stale = 1'b1;
            fifo_cnt = 0;
            model_pc = pctarget;
        end
    endtask

    task automatic runCycles(input int n);
        for (int i = 0; i < n; i++) begin
            applyStimulus();
            @(negedge clk);
            observeCycle();
            cycle++;
            @(posedge clk);
            #1;
        end
    endtask

    task automatic holdReset(input int n);
        rst = 1'b0;
        pend_q.delete();
        exp_q.delete();
        fifo_cnt  = 0;
        model_pc  = 32'h0;
        err_model = 1'b0;
        for (int i = 0; i < n; i++) begin
            pcsrc              = 1'b0;
            bus.imem_req_ready = 1'b1;
            bus.imem_rsp_valid = 1'b0;
            bus.imem_rsp_data  = 32'h0;
            bus.instr_ready    = 1'b1;
            @(negedge clk);
            checkOutput("rst_req_valid", 32'(bus.imem_req_valid), 32'd0);
            checkOutput("rst_req_addr", bus.imem_req_addr, 32'd0);
            checkOutput("rst_instr_valid", 32'(bus.instr_valid), 32'd0);
            checkOutput("rst_instrF", bus.instrF, 32'd0);
            checkOutput("rst_pcF", bus.pcF, 32'd0);
            checkOutput("rst_pcplus4F", bus.pcplus4F, 32'd0);
            checkOutput("rst_rsp_err", 32'(rsp_err), 32'd0);
            @(posedge clk);
            #1;
        end
        rst         = 1'b1;
        cycle       = 0;
        first_valid = -1;
    endtask

    // Monitor: compares the presented head with the scoreboard and pops on consume
    always @(negedge clk) begin
        if (rst && !pcsrc) begin
            if (bus.instr_valid) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("[TB] FAIL unexpected_instr: got pc %h expected no instruction", bus.pcF);
                end else begin
                    checkOutput("instrF", bus.instrF, exp_q[0].instr);
                    checkOutput("pcF", bus.pcF, exp_q[0].pc);
                    checkOutput("pcplus4F", bus.pcplus4F, exp_q[0].pc + 32'd4);
                    if (bus.instr_ready) void'(exp_q.pop_front());
                end
            end else begin
                checkOutput("idle_instrF", bus.instrF, 32'd0);
                checkOutput("idle_pcF", bus.pcF, 32'd0);
                checkOutput("idle_pcplus4F", bus.pcplus4F, 32'd0);
            end
        end
    end

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        bus.imem_req_ready = 1'b0;
        bus.imem_rsp_valid = 1'b0;
        bus.imem_rsp_data  = 32'h0;
        bus.instr_ready    = 1'b0;
        #1 rst = 1'b0;
        @(posedge clk);
        #1;
        holdReset(3);

        // Back-to-back streaming with single-cycle memory
        runCycles(20);
        checkOutput("fetch_latency", 32'(first_valid), 32'd2);

        // Decode stall fills the credit window, then release
        dec_pct = 0;
        runCycles(10);
        dec_pct = 100;
        runCycles(10);

        // Redirect with three requests in flight on slow memory
        lat_min = 3;
        lat_max = 3;
        runCycles(4);
        force_redirect = 1'b1;
        forced_target  = 32'h0000_0100;
        runCycles(20);

        // Address wrap at the top of the address space
        lat_min = 1;
        lat_max = 1;
        force_redirect = 1'b1;
        forced_target  = 32'hFFFF_FFF8;
        runCycles(12);

        // Random traffic with stalls, back-pressure and redirects
        lat_min      = 1;
        lat_max      = 4;
        ready_pct    = 70;
        dec_pct      = 70;
        rsp_pct      = 70;
        redirect_pct = 5;
        runCycles(3000);

        // Quiesce memory, then a response with nothing outstanding
        redirect_pct = 0;
        ready_pct    = 0;
        dec_pct      = 0;
        rsp_pct      = 100;
        for (int i = 0; i < 60 && pend_q.size() > 0; i++) runCycles(1);
        checkOutput("drain_pending", 32'(pend_q.size()), 32'd0);
        runCycles(2);
        force_spurious = 1'b1;
        runCycles(6);

        // Mid-operation reset clears everything, then fetch restarts at 0
        ready_pct = 100;
        dec_pct   = 100;
        lat_min   = 3;
        lat_max   = 3;
        runCycles(5);
        holdReset(2);
        lat_min = 1;
        lat_max = 1;
        runCycles(20);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
